// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR pseudo-random generator.
//
// Advances STEP single-bit shifts per enabled clock using either a Fibonacci
// (external XOR) or Galois (internal XOR) structure. It tracks the seed
// (reset value or last load) and measures the number of enabled cycles
// the sequence takes to return to that seed.
//
// Parameters:
//   WIDTH  state width (>= 2)
//   TAPS   tap mask, bit i = coefficient of x^(i+1); bit WIDTH-1 must be set
//   MODE   0 = Fibonacci, 1 = Galois
//   STEP   single-bit shifts per enabled cycle (1..WIDTH)
//   SEED   reset state, non-zero
//   CNT_W  width of the cycle counter and the period output
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   load      load din as the new state and seed
//   din       load value
//   en        advance STEP shifts this cycle
//   q         current state
//   out_bits  bits shifted out by the last advance, out_bits[0] earliest
//   out_valid out_bits refreshed this cycle (one-cycle pulse)
//   wrap      one-cycle pulse: state returned to the seed
//   period    enabled cycles between the seed and the last wrap
//   zero_fix  one-cycle pulse: a zero load was replaced by SEED
module lfsr_gen #(
    parameter int              WIDTH = 26,
    parameter logic [WIDTH-1:0] TAPS = 26'h2000023,
    parameter int              MODE  = 0,
    parameter int              STEP  = 1,
    parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int              CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic [STEP-1:0]  out_bits,
    output logic             out_valid,
    output logic             wrap,
    output logic [CNT_W-1:0] period,
    output logic             zero_fix
);

    // Configuration sanity: refuse to elaborate a generator that could
    // never run (zero seed locks an XOR LFSR at zero forever).
    if (WIDTH < 2) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be at least 2");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be non-zero");
    end
    if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
        $error("lfsr_gen: STEP must be in 1..WIDTH");
    end
    if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
        $error("lfsr_gen: TAPS[WIDTH-1] must be 1");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("lfsr_gen: MODE must be 0 or 1");
    end

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] seed_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] period_reg;
    logic [STEP-1:0]  out_bits_reg;
    logic             out_valid_reg;
    logic             wrap_reg;
    logic             zero_fix_reg;

    // Unrolled shift chain: stage[0] is the current state, stage[STEP] the
    // state after all shifts of one enabled cycle.
    logic [WIDTH-1:0] stage [0:STEP];
    logic [STEP-1:0]  shift_bits;

    assign stage[0] = q_reg;

    for (genvar gi = 0; gi < STEP; gi++) begin : g_shift
        if (MODE == 0) begin : g_fib
            assign shift_bits[gi] = stage[gi][WIDTH-1];
            assign stage[gi+1]    = {stage[gi][WIDTH-2:0], ^(stage[gi] & TAPS)};
        end else begin : g_gal
            assign shift_bits[gi] = stage[gi][0];
            assign stage[gi+1]    = (stage[gi] >> 1) ^ (stage[gi][0] ? TAPS : '0);
        end
    end

    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit_seed;
    logic             din_zero;

    assign q_next   = stage[STEP];
    // Counter saturates rather than wrapping so an over-long period reads
    // as all-ones instead of a misleading small number.
    assign cnt_inc  = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
    assign hit_seed = (q_next == seed_reg);
    assign din_zero = (din == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg         <= SEED;
            seed_reg      <= SEED;
            cnt_reg       <= '0;
            period_reg    <= '0;
            out_bits_reg  <= '0;
            out_valid_reg <= 1'b0;
            wrap_reg      <= 1'b0;
            zero_fix_reg  <= 1'b0;
        end else if (load) begin
            // A zero load would lock the generator, so substitute SEED.
            q_reg         <= din_zero ? SEED : din;
            seed_reg      <= din_zero ? SEED : din;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            wrap_reg      <= 1'b0;
            zero_fix_reg  <= din_zero;
        end else if (en) begin
            q_reg         <= q_next;
            out_bits_reg  <= shift_bits;
            out_valid_reg <= 1'b1;
            zero_fix_reg  <= 1'b0;
            if (hit_seed) begin
                wrap_reg   <= 1'b1;
                period_reg <= cnt_inc;
                cnt_reg    <= '0;
            end else begin
                wrap_reg   <= 1'b0;
                cnt_reg    <= cnt_inc;
            end
        end else begin
            out_valid_reg <= 1'b0;
            wrap_reg      <= 1'b0;
            zero_fix_reg  <= 1'b0;
        end
    end

    assign q         = q_reg;
    assign out_bits  = out_bits_reg;
    assign out_valid = out_valid_reg;
    assign wrap      = wrap_reg;
    assign period    = period_reg;
    assign zero_fix  = zero_fix_reg;

endmodule
